sseg_p2s: RTL and testbench

- Serial transmitter for the board's 8-digit seven-segment shift-register chain.
- Accepts the 64-bit, already segment-ordered pattern produced by the segment-mapping stage and shifts it out MSB first on s_clk/s_out.
- After the last bit, pulses a latch strobe, then reports completion.
- Sits between the display mapping logic and the top-level board pins.

---
 rtl/sseg_pkg.sv | 16 +
 rtl/sseg_tick_gen.sv | 43 ++++
 rtl/sseg_p2s.sv | 148 ++++++++++++++
 tb/tb_sseg_p2s.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment serial transmitter.
//   sseg_state_t     : transmitter FSM states
//   SSEG_DATA_W      : default frame width in bits
//   SSEG_DIV_DEFAULT : default s_clk half-period in clk cycles
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } sseg_state_t;

    localparam int unsigned SSEG_DATA_W      = 64;
    localparam int unsigned SSEG_DIV_DEFAULT = 4;

endpackage

// File: rtl/sseg_tick_gen.sv
// Divider tick generator for the serial clock.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count while high, hold at zero while low
//   tick  : one-cycle pulse every DIV enabled cycles
module sseg_tick_gen
    import sseg_pkg::*;
#(
    parameter int unsigned DIV = SSEG_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;

    always_comb begin
        tick      = 1'b0;
        div_cnt_d = div_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            tick      = 1'b1;
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/sseg_p2s.sv
// Parallel-to-serial transmitter for the 8-digit seven-segment shift chain.
// Shifts a DATA_W-bit pattern out MSB first, then pulses the latch strobe.
//   clk, rst_n : system clock, asynchronous active-low reset
//   in_valid   : request to transmit in_data (accepted while in_ready)
//   in_data    : segment pattern, bit DATA_W-1 sent first
//   in_ready   : idle and able to accept a frame
//   busy       : frame in progress (shifting or latching)
//   done       : one-cycle completion pulse
//   s_clk      : serial clock, s_out : serial data
//   s_pen      : latch strobe (active high), s_clrn : chain clear (active low)
module sseg_p2s
    import sseg_pkg::*;
#(
    parameter int unsigned DATA_W = SSEG_DATA_W,
    parameter int unsigned DIV    = SSEG_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_out,
    output logic              s_pen,
    output logic              s_clrn
);

    // One spare bit so the count can reach DATA_W without wrapping.
    localparam int unsigned     BC_W    = $clog2(DATA_W) + 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    sseg_state_t       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              s_clk_q, s_clk_d;
    logic              s_out_q, s_out_d;
    logic              s_pen_q, s_pen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
    logic              s_clrn_q, s_clrn_d;
    logic              tick;

    sseg_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        s_clk_d    = s_clk_q;
        s_out_d    = s_out_q;
        s_pen_d    = s_pen_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        in_ready_d = in_ready_q;
        s_clrn_d   = 1'b1;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    shreg_d    = in_data;
                    s_out_d    = in_data[DATA_W-1];
                    s_clk_d    = 1'b0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!s_clk_q) begin
                        s_clk_d = 1'b1;
                    end else begin
                        // Falling toggle ends the current bit.
                        s_clk_d   = 1'b0;
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == BC_LAST) begin
                            s_out_d = 1'b0;
                            s_pen_d = 1'b1;
                            state_d = LATCH;
                        end else begin
                            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                            s_out_d = shreg_q[DATA_W-2];
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    s_pen_d    = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            s_clk_q    <= 1'b0;
            s_out_q    <= 1'b0;
            s_pen_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            s_clrn_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            s_clk_q    <= s_clk_d;
            s_out_q    <= s_out_d;
            s_pen_q    <= s_pen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            s_clrn_q   <= s_clrn_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign s_clk    = s_clk_q;
    assign s_out    = s_out_q;
    assign s_pen    = s_pen_q;
    assign s_clrn   = s_clrn_q;

endmodule

// File: tb/tb_sseg_p2s.sv
// Bench for sseg_p2s: three instances (DIV=2, 4, 1) share one clock.
// Stimulus pushes expected frames; per-instance monitors capture the serial
// stream and compare at each done pulse.
module tb_sseg_p2s;

    typedef struct {
        int          ch;
        logic [63:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n = '0;
    logic [2:0]  in_valid = '0;
    logic [63:0] in_data [3];
    logic [2:0]  in_ready, busy, done_o, s_clk, s_out, s_pen, s_clrn;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q [$];
    int   last_done [3];
    int   prev_done [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int ch);
        return (ch == 0) ? 2 : ((ch == 1) ? 4 : 1);
    endfunction

    // Reference latency: every bit is one full s_clk period, then DIV latch cycles.
    function automatic int lat_of(input int ch);
        return 2 * div_of(ch) * 64 + div_of(ch);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int D = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        int          nbits = 0;
        int          load_cyc = 0;
        int          last_rise = 0;
        int          pen_cnt = 0;
        logic        prev_sclk = 1'b0;
        logic [63:0] bits = '0;
        exp_t        e;

        sseg_p2s #(
            .DATA_W (64),
            .DIV    (D)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .in_valid (in_valid[g]),
            .in_data  (in_data[g]),
            .in_ready (in_ready[g]),
            .busy     (busy[g]),
            .done     (done_o[g]),
            .s_clk    (s_clk[g]),
            .s_out    (s_out[g]),
            .s_pen    (s_pen[g]),
            .s_clrn   (s_clrn[g])
        );

        always @(negedge clk) begin
            if (!rst_n[g]) begin
                nbits     = 0;
                pen_cnt   = 0;
                prev_sclk = 1'b0;
                bits      = '0;
            end else begin
                if (busy[g]) chk("ready_while_busy", 64'(in_ready[g]), 64'd0);
                if (s_clk[g] && !prev_sclk) begin
                    if (nbits == 0) chk("first_rise", 64'(cyc - load_cyc), 64'(D));
                    else            chk("rise_gap", 64'(cyc - last_rise), 64'(2 * D));
                    last_rise = cyc;
                    bits      = {bits[62:0], s_out[g]};
                    nbits++;
                end
                prev_sclk = s_clk[g];
                if (s_pen[g]) begin
                    pen_cnt++;
                    chk("latch_sclk", 64'(s_clk[g]), 64'd0);
                    chk("latch_sout", 64'(s_out[g]), 64'd0);
                end
                if (done_o[g]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_channel", 64'(g), 64'(e.ch));
                        chk("stream", bits, e.data);
                        chk("bit_count", 64'(nbits), 64'd64);
                        chk("pen_len", 64'(pen_cnt), 64'(D));
                        chk("latency", 64'(cyc - load_cyc), 64'(e.lat));
                    end
                    prev_done[g] = last_done[g];
                    last_done[g] = cyc;
                end
                if (in_valid[g] && in_ready[g]) begin
                    load_cyc = cyc + 1;
                    nbits    = 0;
                    pen_cnt  = 0;
                    bits     = '0;
                end
            end
        end
    end

    task automatic wait_ready(input int ch);
        int n = 0;
        while (!in_ready[ch] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[ch]) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic push_exp(input int ch, input logic [63:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        e.lat  = lat_of(ch);
        exp_q.push_back(e);
    endtask

    task automatic send(input int ch, input logic [63:0] d);
        @(posedge clk); #1;
        wait_ready(ch);
        in_valid[ch] = 1'b1;
        in_data[ch]  = d;
        push_exp(ch, d);
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    // Returns just after the negedge that follows the done pulse.
    task automatic wait_done(input int ch);
        int n = 0;
        while (!done_o[ch] && n < 1200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_o[ch]) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk); #1;
    endtask

    task automatic chk_reset_vals(input int ch);
        chk("rst_in_ready", 64'(in_ready[ch]), 64'd0);
        chk("rst_busy",     64'(busy[ch]),     64'd0);
        chk("rst_done",     64'(done_o[ch]),   64'd0);
        chk("rst_s_clk",    64'(s_clk[ch]),    64'd0);
        chk("rst_s_out",    64'(s_out[ch]),    64'd0);
        chk("rst_s_pen",    64'(s_pen[ch]),    64'd0);
        chk("rst_s_clrn",   64'(s_clrn[ch]),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        for (int i = 0; i < 3; i++) begin
            in_data[i]   = '0;
            last_done[i] = 0;
            prev_done[i] = 0;
        end

        // Reset
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk_reset_vals(i);
        end
        rst_n = '1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("clrn_before_edge",  64'(s_clrn[i]),   64'd0);
            chk("ready_before_edge", 64'(in_ready[i]), 64'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("clrn_after_edge",  64'(s_clrn[i]),   64'd1);
            chk("ready_after_edge", 64'(in_ready[i]), 64'd1);
        end

        // Single frame, DIV=2
        send(0, 64'h8000_0000_0000_0001);
        wait_done(0);

        // Back-to-back, DIV=4
        a = 64'hA5A5_A5A5_5A5A_5A5A;
        b = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); #1;
        wait_ready(1);
        in_valid[1] = 1'b1;
        in_data[1]  = a;
        push_exp(1, a);
        @(posedge clk); #1;
        in_data[1] = b;
        push_exp(1, b);
        wait_done(1);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        chk("b2b_load_edge", 64'(mon[1].load_cyc), 64'(last_done[1] + 1));
        wait_done(1);
        chk("b2b_done_gap", 64'(last_done[1] - prev_done[1]), 64'(lat_of(1) + 1));

        // Busy collision
        a = {$urandom, $urandom};
        send(1, a);
        repeat (100) @(posedge clk);
        #1;
        in_valid[1] = 1'b1;
        in_data[1]  = ~a;
        repeat (10) @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        wait_done(1);
        repeat (30) @(posedge clk);
        #1;
        chk("collision_no_extra_done", 64'(last_done[1] - prev_done[1] > 0 ? 1 : 0), 64'd1);

        // Mid-frame reset at bit 30
        send(1, {$urandom, $urandom});
        for (int i = 0; i < 1000 && mon[1].nbits < 31; i++) @(negedge clk);
        chk("reached_bit30", 64'(mon[1].nbits >= 31 ? 1 : 0), 64'd1);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("abort_s_clk",  64'(s_clk[1]),  64'd0);
        chk("abort_s_out",  64'(s_out[1]),  64'd0);
        chk("abort_s_pen",  64'(s_pen[1]),  64'd0);
        chk("abort_s_clrn", 64'(s_clrn[1]), 64'd0);
        chk("abort_busy",   64'(busy[1]),   64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        send(1, 64'hC3E1_0F5A_9600_7B24);
        wait_done(1);

        // DIV=1 boundary
        send(2, 64'h0123_4567_89AB_CDEF);
        wait_done(2);

        // Random frames on every instance
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 2; k++) begin
                send(ch, {$urandom, $urandom});
                wait_done(ch);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
